// File: rtl/ddr_beat_padder_pkg.sv
// Shared constants for the DDR3 FIFO wrapper datapath and the beat padder.
// Contents:
//   DDR_BEAT_WORDS  16-bit words per 128-bit DDR burst
//   DDR_DQ_WIDTH    width of one AXIS word on the wrapper's 16-bit port
//   pad_state_t     padder FSM states (PASS / PAD)
//   sat_inc16       saturating 16-bit increment used by statistics counters
package ddr_beat_padder_pkg;

    localparam int DDR_BEAT_WORDS = 8;
    localparam int DDR_DQ_WIDTH   = 16;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_PAD  = 1'b1
    } pad_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXIS output slice: one data/last/valid register stage with
// load/hold handling. Shared by the write-side padder and the wrapper's read
// side.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_load     load i_data/i_last this cycle (only asserted when o_free=1)
//   i_data     word to register
//   i_last     tlast to register
//   o_free     register may be loaded this cycle (empty or draining)
//   o_valid    AXIS tvalid toward the sink
//   i_ready    AXIS tready from the sink
//   o_data     AXIS tdata toward the sink
//   o_last     AXIS tlast toward the sink
module axis_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_free,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // The slot can take a new word when it is empty or its word leaves now.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            // data/last are left untouched so a stalled word never changes
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr_beat_padder.sv
// Beat padder in front of the DDR3 FIFO wrapper's 16-bit AXIS write port.
// Re-times the user stream and makes sure words reach the wrapper in whole
// groups of BEAT_WORDS (one DDR burst). A partial group is filled with
// PAD_WORD when the frame ends (tlast) or the input has been idle for TIMEOUT
// cycles.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_axis_*        upstream 16-bit AXIS (tvaild/tready/tdata/tlast)
//   m_axis_*        downstream AXIS to the wrapper; tlast marks group ends
//   pad_busy        high while padding a group
//   pad_count       total pad words emitted, saturating at 16'hFFFF
module ddr_beat_padder
    import ddr_beat_padder_pkg::*;
#(
    parameter int                      BEAT_WORDS = DDR_BEAT_WORDS,
    parameter logic [DDR_DQ_WIDTH-1:0] PAD_WORD   = '0,
    parameter int                      TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvaild,
    output logic                    s_axis_tready,
    input  logic [DDR_DQ_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvaild,
    input  logic                    m_axis_tready,
    output logic [DDR_DQ_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    pad_busy,
    output logic [15:0]             pad_count
);

    localparam int IDX_W = $clog2(BEAT_WORDS);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_WORDS - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

    pad_state_t              r_state;
    pad_state_t              w_state_nxt;
    logic [IDX_W-1:0]        r_word_idx;
    logic [CNT_W-1:0]        r_idle_cnt;
    logic [15:0]             r_pad_count;

    logic                    w_free;
    logic                    w_in_pass;
    logic                    w_accept;
    logic                    w_pad_emit;
    logic                    w_load;
    logic                    w_at_last;
    logic                    w_timeout;
    logic [DDR_DQ_WIDTH-1:0] w_load_data;

    assign w_in_pass     = (r_state == ST_PASS);
    assign s_axis_tready = w_in_pass && w_free;
    assign w_accept      = s_axis_tvaild && s_axis_tready;
    assign w_pad_emit    = !w_in_pass && w_free;
    assign w_load        = w_accept || w_pad_emit;
    assign w_at_last     = (r_word_idx == LAST_IDX);
    assign w_load_data   = w_in_pass ? s_axis_tdata : PAD_WORD;
    // Only a partially filled group can time out.
    assign w_timeout     = (r_word_idx != '0) && (r_idle_cnt == IDLE_MAX);
    assign pad_busy      = !w_in_pass;
    assign pad_count     = r_pad_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PASS: begin
                // An accepted word always beats an expiring timer.
                if (w_accept) begin
                    if (s_axis_tlast && !w_at_last) begin
                        w_state_nxt = ST_PAD;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                if (w_free && w_at_last) begin
                    w_state_nxt = ST_PASS;
                end
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_PASS;
            r_word_idx  <= '0;
            r_idle_cnt  <= '0;
            r_pad_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            // BEAT_WORDS is a power of two, so the natural wrap is the modulo.
            if (w_load) begin
                r_word_idx <= r_word_idx + IDX_W'(1);
            end
            // The timer keeps running while the output is stalled.
            if (w_accept || (r_word_idx == '0)) begin
                r_idle_cnt <= '0;
            end else if (w_in_pass && (r_idle_cnt != IDLE_MAX)) begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
            if (w_pad_emit) begin
                r_pad_count <= sat_inc16(r_pad_count);
            end
        end
    end

    axis_out_reg #(
        .DATA_W (DDR_DQ_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_at_last),
        .o_free  (w_free),
        .o_valid (m_axis_tvaild),
        .i_ready (m_axis_tready),
        .o_data  (m_axis_tdata),
        .o_last  (m_axis_tlast)
    );

endmodule

// File: tb/tb_ddr_beat_padder.sv
module tb_ddr_beat_padder;
    import ddr_beat_padder_pkg::*;

    localparam int          BW   = 8;
    localparam int          TO   = 16;
    localparam logic [15:0] PADW = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvaild;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        s_tlast;
    logic        m_tvaild;
    logic        m_tready;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        pad_busy;
    logic [15:0] pad_count;

    ddr_beat_padder #(
        .BEAT_WORDS (BW),
        .PAD_WORD   (PADW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvaild (s_tvaild),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvaild (m_tvaild),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .pad_busy      (pad_busy),
        .pad_count     (pad_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected output word stream, group fill level,
    // cycles since the last accepted word, and total pads.
    logic [15:0] exp_q[$];
    int          grp_cnt    = 0;
    int          gap        = 0;
    int          out_idx    = 0;
    int          pads_total = 0;
    int          cyc        = 0;
    int          last_acc   = 0;
    logic        rnd_rdy    = 1'b0;
    logic        held_v     = 1'b0;
    logic [15:0] held_d;
    logic        held_l;
    logic [15:0] exp_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic add_pads();
        int n;
        n = BW - grp_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back(PADW);
        pads_total = (pads_total + n > 65535) ? 65535 : pads_total + n;
        grp_cnt = 0;
    endtask

    // Values seen at the falling edge are what the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            grp_cnt    = 0;
            gap        = 0;
            out_idx    = 0;
            pads_total = 0;
            held_v     = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", {31'd0, m_tvaild}, 32'd1);
                check("hold_data", {16'd0, m_tdata}, {16'd0, held_d});
                check("hold_last", {31'd0, m_tlast}, {31'd0, held_l});
            end
            held_v = m_tvaild && !m_tready;
            held_d = m_tdata;
            held_l = m_tlast;
            if (m_tvaild && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {16'd0, m_tdata}, 32'hDEAD_BEEF);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_data", {16'd0, m_tdata}, {16'd0, exp_w});
                    check("out_last", {31'd0, m_tlast}, {31'd0, out_idx == BW - 1});
                end
                out_idx = (out_idx + 1) % BW;
            end
            if (s_tvaild && s_tready) begin
                exp_q.push_back(s_tdata);
                grp_cnt  = (grp_cnt + 1) % BW;
                gap      = 0;
                last_acc = cyc + 1;
                if (s_tlast && grp_cnt != 0) add_pads();
            end else begin
                gap++;
                if (grp_cnt != 0 && gap == TO) add_pads();
            end
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        s_tvaild = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 500) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvaild = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && grp_cnt == 0 && !pad_busy && !m_tvaild)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                check("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvaild"}, {31'd0, m_tvaild}, 32'd0);
        check({tag, "_tdata"}, {16'd0, m_tdata}, 32'd0);
        check({tag, "_tlast"}, {31'd0, m_tlast}, 32'd0);
        check({tag, "_busy"}, {31'd0, pad_busy}, 32'd0);
        check({tag, "_padcnt"}, {16'd0, pad_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        int len;
        logic wl;
        rst      = 1'b1;
        s_tvaild = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two full groups, no padding.
        for (int i = 1; i <= 16; i++) send(16'(i * 16'h0101), i == 16);
        drain();
        check("s1_padcnt", {16'd0, pad_count}, 32'd0);

        // Three words then tlast: five pads, upstream blocked five cycles.
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0033, 1'b1);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_tready) break;
            n++;
        end
        check("s2_block_cycles", n, 32'd5);
        drain();
        check("s2_padcnt", {16'd0, pad_count}, 32'd5);

        // Five words then idle: timeout padding latency.
        for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
        n = 0;
        while (!pad_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s3_timeout_lat", cyc - last_acc, TO);
        drain();
        check("s3_padcnt", {16'd0, pad_count}, 32'd8);

        // Word arriving on the expiry cycle wins; no padding.
        for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
        idle(TO - 1);
        send(16'h0606, 1'b0);
        @(negedge clk);
        check("s3_race_busy", {31'd0, pad_busy}, 32'd0);
        @(posedge clk);
        #1;
        send(16'h0707, 1'b0);
        send(16'h0808, 1'b1);
        drain();
        check("s3_race_padcnt", {16'd0, pad_count}, 32'd8);

        // Short frame under random back-pressure.
        rnd_rdy = 1'b1;
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        send(16'h0033, 1'b1);
        drain();
        check("s4_padcnt", {16'd0, pad_count}, 32'd13);

        // Random frames, gaps and back-pressure.
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 20);
            wl  = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < len; i++) begin
                send(16'($urandom), wl && (i == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) idle(TO + 3);
            else idle($urandom_range(0, 3));
        end
        idle(TO + 2);
        drain();
        check("rand_padcnt", {16'd0, pad_count}, pads_total);
        rnd_rdy = 1'b0;
        idle(2);

        // Reset in the middle of padding.
        base = pad_count;
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        send(16'h0303, 1'b1);
        n = 0;
        while (pad_count != 16'(base + 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s5_reach_pad2", {16'd0, pad_count}, base + 2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s5_async");
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(16'(16'h1000 + i), i == 7);
        drain();
        check("s5_padcnt", {16'd0, pad_count}, 32'd0);

        // Saturation of the pad statistic.
        force dut.r_pad_count = 16'hFFFE;
        pads_total = 65534;
        @(posedge clk);
        #1;
        release dut.r_pad_count;
        send(16'h1234, 1'b1);
        drain();
        check("s6_sat", {16'd0, pad_count}, 32'h0000FFFF);
        send(16'h5678, 1'b1);
        drain();
        check("s6_nowrap", {16'd0, pad_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
